memory_responder: RTL

// - Responder end of the control unit's memory strobes: services fetch, mem_read, mem_write against a

---
 rtl/memory_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Word-array responder for fetch/read/write strobes; optional range checking via MEM_BOUNDS_EN.
// Latency: capture edge + 1 + WAIT_STATES edges to a one-cycle done pulse.
// Backpressure: none; one access in service, one fetch buffered, extra data requests dropped (overrun).
module memory_responder #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 20,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] instruction,
   output logic [DATA_W-1:0] rdata,
   output logic              inst_done,
   output logic              data_done,
   output logic              busy,
   output logic              overrun,
   output logic              addr_error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_FE} op_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   op_t               cur_op;
   op_t               fin_op;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_vld;
   logic              prev_fetch, prev_read, prev_write;
   logic              fetch_rise, rd_rise, wr_rise;
   logic              consume;
   logic              fin;
   logic [ADDR_W-1:0] acc_addr;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;
   logic              wr_en;

   assign fetch_rise = fetch & ~prev_fetch;
   assign rd_rise    = mem_read & ~prev_read;
   assign wr_rise    = mem_write & ~prev_write;

   // A buffered fetch is started straight out of DONE, so the access port follows it there.
   assign consume  = (state == DONE) && pend_vld;
   assign acc_addr = consume ? pend_addr : cur_addr;
   assign fin_op   = consume ? OP_FE : cur_op;
   assign fin      = ((state == REQ) && (WS == 4'd0)) ||
                     ((state == WAIT) && (cnt == 4'd1)) ||
                     (consume && (WS == 4'd0));
   assign idx      = IDX_W'({1'b0, acc_addr} % DEPTH_X);

`ifdef MEM_BOUNDS_EN
   logic in_range;
   assign in_range = ({1'b0, acc_addr} < DEPTH_X);
   assign rd_word  = in_range ? mem[idx] : '0;
   assign wr_en    = fin && (fin_op == OP_WR) && in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr_error <= 1'b0;
      else if (fin && !in_range)
         addr_error <= 1'b1;
   end
`else
   assign rd_word    = mem[idx];
   assign wr_en      = fin && (fin_op == OP_WR);
   assign addr_error = 1'b0;
`endif

   // Array is deliberately outside the reset domain: contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[idx] <= cur_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cur_op      <= OP_RD;
         cnt         <= 4'd0;
         cur_addr    <= '0;
         cur_wdata   <= '0;
         pend_addr   <= '0;
         pend_vld    <= 1'b0;
         prev_fetch  <= 1'b0;
         prev_read   <= 1'b0;
         prev_write  <= 1'b0;
         instruction <= '0;
         rdata       <= '0;
         inst_done   <= 1'b0;
         data_done   <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         prev_fetch <= fetch;
         prev_read  <= mem_read;
         prev_write <= mem_write;
         inst_done  <= 1'b0;
         data_done  <= 1'b0;

         case (state)
            IDLE: begin
               if (wr_rise || rd_rise) begin
                  cur_op    <= wr_rise ? OP_WR : OP_RD;
                  cur_addr  <= addr;
                  cur_wdata <= wdata;
                  state     <= REQ;
                  busy      <= 1'b1;
                  if (wr_rise && rd_rise)
                     overrun <= 1'b1;
                  if (fetch_rise) begin
                     if (pend_vld)
                        overrun <= 1'b1;
                     pend_vld  <= 1'b1;
                     pend_addr <= pc_addr;
                  end
               end else if (pend_vld) begin
                  cur_op    <= OP_FE;
                  cur_addr  <= pend_addr;
                  state     <= REQ;
                  busy      <= 1'b1;
                  pend_vld  <= fetch_rise;
                  if (fetch_rise)
                     pend_addr <= pc_addr;
               end else if (fetch_rise) begin
                  cur_op   <= OP_FE;
                  cur_addr <= pc_addr;
                  state    <= REQ;
                  busy     <= 1'b1;
               end
            end
            REQ: begin
               cnt <= WS;
               if (WS != 4'd0)
                  state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
            end
            DONE: begin
               if (pend_vld) begin
                  cur_op   <= OP_FE;
                  cur_addr <= pend_addr;
                  pend_vld <= 1'b0;
                  cnt      <= WS;
                  if (WS != 4'd0)
                     state <= WAIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Arrivals while an access is in flight (DONE cycle included).
         if (state != IDLE) begin
            if (rd_rise || wr_rise)
               overrun <= 1'b1;
            if (fetch_rise) begin
               if (pend_vld && !consume)
                  overrun <= 1'b1;
               pend_vld  <= 1'b1;
               pend_addr <= pc_addr;
            end
         end

         if (fin) begin
            state <= DONE;
            busy  <= 1'b1;
            if (fin_op == OP_FE) begin
               instruction <= rd_word;
               inst_done   <= 1'b1;
            end else begin
               data_done <= 1'b1;
               if (fin_op == OP_RD)
                  rdata <= rd_word;
            end
         end
      end
   end

endmodule
